// File: rtl/spi_master_tx_if.sv
// Control and serial-line signals of the single-byte SPI master.
// The master modport is the DUT's view; the slave modport is whatever drives and observes it.
interface spi_master_tx_if;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       miso;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, ss, sclk, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, ss, sclk, mosi
    );
endinterface

// File: rtl/spi_master_tx.sv
// Single-byte SPI master, mode 0, MSB first, full duplex.
// Every output is decoded from registered state only.
module spi_master_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            reset,
    spi_master_tx_if.master bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CP0  = 2'd1;
    localparam logic [1:0] CP1  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [1:0] state_q,    state_d;
    logic [7:0] div_cnt_q,  div_cnt_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       done_q,     done_d;

    logic div_last;

    assign div_last = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // start is only looked at here, so requests while busy are dropped
                if (bus.start) begin
                    tx_shift_d = bus.tx_data;
                    bit_cnt_d  = 3'd0;
                    div_cnt_d  = 8'd0;
                    state_d    = CP0;
                end
            end

            CP0: begin
                if (div_last) begin
                    div_cnt_d = 8'd0;
                    state_d   = CP1;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            CP1: begin
                // miso is sampled once, one clk after sclk rises
                if (div_cnt_q == 8'd0) begin
                    rx_shift_d = {rx_shift_q[6:0], bus.miso};
                end
                if (div_last) begin
                    div_cnt_d = 8'd0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        state_d    = CP0;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            DONE: begin
                // trailing low half-period lets the slave see the last sclk fall under ss
                if (div_last) begin
                    div_cnt_d = 8'd0;
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= 8'd0;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= 8'd0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
        end
    end

    assign bus.ss      = (state_q != IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.sclk    = (state_q == CP1);
    assign bus.mosi    = (state_q != IDLE) & tx_shift_q[7];
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- Single-byte SPI master: mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
- Sits directly upstream of the SPI slave receiver. Drives its chip-select/start, sclk and mosi inputs, and samples its miso output.
- Controlled from the local control side by a start request carrying an 8-bit payload. Returns the byte received on miso together with a one-cycle done pulse.

Parameters:
- CLK_DIV, 4, system clk cycles per sclk half-period; legal range 2..255.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  transfer request; sampled only in IDLE.
- tx_data  input  8  byte to send; latched on the accepted start.
- busy  output  1  high from the cycle after start is accepted until the done pulse.
- done  output  1  one-cycle pulse when the transfer completes.
- rx_data  output  8  last byte received on miso; held between transfers.
- ss  output  1  active-high chip select to the slave's start input.
- sclk  output  1  serial clock, idles low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

Behaviour:
- Registers: state, div_cnt[7:0], bit_cnt[2:0], tx_shift[7:0], rx_shift[7:0], rx_data_reg[7:0], done_reg.
- Outputs are decoded from registers only; there is no combinational path from any input to any output.
- Reset (reset=0, async): state=IDLE, all counters and shift registers 0, rx_data=0, done=0, busy=0, ss=0, sclk=0, mosi=0.
- Reset mid-transfer: abort immediately, all outputs return to idle values in the same instant, no done pulse, rx_data cleared to 0.
- Output decode:
  - ss=1 whenever state!=IDLE.
  - sclk=1 only in CP1.
  - mosi=tx_shift[7] while ss=1, else 0.
  - busy=(state!=IDLE).
- IDLE: if start=1, then tx_shift<=tx_data, bit_cnt<=0, div_cnt<=0, go to CP0. Otherwise stay.
- CP0 (sclk low, mosi set up):
  - div_cnt increments each cycle.
  - At div_cnt==CLK_DIV-1: div_cnt<=0, go to CP1.
- CP1 (sclk high):
  - On the first cycle (div_cnt==0): rx_shift<={rx_shift[6:0], miso}.
  - At div_cnt==CLK_DIV-1: div_cnt<=0.
  - If bit_cnt==7, go to DONE.
  - Otherwise tx_shift<=tx_shift<<1, bit_cnt<=bit_cnt+1, go to CP0.
- DONE (ss=1, sclk=0): trailing half-period so the slave observes the final sclk fall.
  - At div_cnt==CLK_DIV-1: rx_data_reg<=rx_shift, done_reg<=1, go to IDLE.
- done_reg clears on the next clock, so it is exactly one cycle wide.
- Latency: start sampled at edge E0 gives done high in the cycle after edge E0+17*CLK_DIV.
- The transfer spans 8 CP0 + 8 CP1 + 1 DONE half-periods.
- Back-to-back:
  - start held high during the done cycle is accepted in that same cycle (state is IDLE).
  - ss is low for exactly one cycle between transfers, which the slave's IDLE observes.
- start while busy is ignored; it is neither queued nor allowed to corrupt tx_shift.
- tx_data changes after acceptance have no effect on the transfer in progress.
- bit_cnt does not wrap within a transfer: the CP1 of bit 7 always exits to DONE.
- Exactly 8 rising sclk edges occur per transfer, and no sclk edge occurs while ss=0.

Test Plan:
- Reset: hold reset=0 with random start and tx_data → ss=0, sclk=0, mosi=0, busy=0, done=0, rx_data=0 throughout. Release reset → outputs unchanged until start.
- Basic transfer (CLK_DIV=4):
  - Stimulus: start pulse with tx_data=0xA5, miso driven from a model returning 0x3C MSB-first.
  - mosi at each of the 8 sclk rising edges → 1,0,1,0,0,1,0,1.
  - Each sclk high and low phase → exactly 4 cycles.
  - done → single pulse 68 cycles after start acceptance.
  - rx_data → 0x3C.
- Loopback with the slave receiver (mosi→slave, ss→start) for bytes 0x00, 0xFF, 0x81 → slave rx_data equals each byte, slave done pulses once per transfer, master done follows.
- Busy-ignore: start with tx_data=0x12, then start with 0x34 mid-transfer → only 0x12 is shifted out, one done pulse, busy stays high throughout.
- Back-to-back: start held high continuously with tx_data=0x55 then 0xAA → two transfers, ss low for exactly 1 cycle between them, two done pulses 69 cycles apart.
- Mid-transfer reset: assert reset=0 after the 3rd sclk rising edge → ss, sclk and busy drop immediately, no done pulse, rx_data=0. A subsequent start with 0xC3 completes normally.
